// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the two-port round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  // Output-stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_N  = 32;
  localparam int DEF_CW = 8;

endpackage

// File: rtl/mux2_rr_arbiter_sat_counter.sv
// Saturating up-counter, sticks at all-ones instead of wrapping.
// Latency: count reflects an increment one cycle after i_inc.
// Backpressure: none; i_inc is ignored once saturated.
module sat_counter
  import arb_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // Count up on enable, hold at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-port round-robin arbiter driving a shared 2:1 mux into a one-entry output register.
// Latency: one cycle from accepted input to out_valid; 1 word/cycle sustained.
// Backpressure: readies drop while the held word is stalled; ARB_FIXED_PRIO_EN makes port 0 always win ties.
module mux2_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in0_valid,
  input  logic [N-1:0]  in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [N-1:0]  in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic          out_sel,
  input  logic          out_ready,
  output logic [CW-1:0] gnt_cnt0,
  output logic [CW-1:0] gnt_cnt1
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_data;
  logic         r_sel;
  logic         w_can_accept;
  logic         w_winner;
  logic         w_grant;
  logic [N-1:0] w_win_data;

`ifndef ARB_FIXED_PRIO_EN
  logic         r_prio;
`endif

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Winner pick, readies and next occupancy; a grant never fires during reset
  always_comb begin
    w_state_nxt  = r_state;
    w_can_accept = 1'b0;
    w_winner     = PORT0;
    w_grant      = 1'b0;
    w_win_data   = in0_data;
    in0_ready    = 1'b0;
    in1_ready    = 1'b0;

    case (r_state)
      ST_EMPTY: w_can_accept = 1'b1;
      ST_FULL:  w_can_accept = out_ready;
      default:  w_can_accept = 1'b0;
    endcase

    if (in0_valid && in1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
      w_winner = PORT0;
`else
      w_winner = r_prio;
`endif
    end else if (in1_valid) begin
      w_winner = PORT1;
    end else begin
      w_winner = PORT0;
    end

    w_win_data = (w_winner == PORT1) ? in1_data : in0_data;
    w_grant    = w_can_accept && (in0_valid || in1_valid) && !reset;
    in0_ready  = w_grant && (w_winner == PORT0);
    in1_ready  = w_grant && (w_winner == PORT1);

    if (w_grant) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Capture the winning word and its source; held untouched while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_sel  <= PORT0;
    end else if (w_grant) begin
      r_data <= w_win_data;
      r_sel  <= w_winner;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Priority flips to the loser only when somebody is actually granted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= PORT0;
    end else if (w_grant) begin
      r_prio <= ~w_winner;
    end
  end
`endif

  sat_counter #(.CW(CW)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_grant && (w_winner == PORT0)),
    .o_cnt (gnt_cnt0)
  );

  sat_counter #(.CW(CW)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_grant && (w_winner == PORT1)),
    .o_cnt (gnt_cnt1)
  );

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
